// File: rtl/oldland_write_buffer.sv
// Posted write buffer: queues writes in a small FIFO with early acks and drains them to memory in order,
// while forwarding reads, letting them overtake queued writes only when no queued address matches.
module oldland_write_buffer #(
  parameter int DEPTH       = 4,
  parameter bit MERGE       = 1'b1,
  parameter bit READ_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_access,
  input  logic [29:0] c_addr,
  input  logic        c_wr_en,
  input  logic [31:0] c_wr_val,
  input  logic [3:0]  c_bytesel,
  output logic [31:0] c_data,
  output logic        c_ack,
  output logic        c_error,
  input  logic        c_flush,
  output logic        flush_complete,
  output logic        m_access,
  output logic [29:0] m_addr,
  output logic [31:0] m_wr_val,
  output logic        m_wr_en,
  output logic [3:0]  m_bytesel,
  input  logic [31:0] m_data,
  input  logic        m_ack,
  input  logic        m_error,
  output logic        wb_empty,
  output logic        wb_full,
  output logic        err_sticky,
  output logic [29:0] err_addr,
  input  logic        err_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               req_valid_q, req_valid_d;
  logic               req_wr_q, req_wr_d;
  logic [29:0]        req_addr_q, req_addr_d;
  logic [31:0]        req_val_q, req_val_d;
  logic [3:0]         req_bsel_q, req_bsel_d;
  logic               rd_ack_q, rd_ack_d;
  logic               rd_err_q, rd_err_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               flush_pending_q, flush_pending_d;
  logic               err_sticky_q, err_sticky_d;
  logic [29:0]        err_addr_q, err_addr_d;

  logic [29:0]        fifo_addr_q [DEPTH];
  logic [31:0]        fifo_val_q  [DEPTH];
  logic [3:0]         fifo_bsel_q [DEPTH];

  logic [PTR_W-1:0]   youngest;
  logic [DEPTH-1:0]   hit;
  logic [31:0]        merge_val;
  logic               fifo_empty, full, head_busy;
  logic               can_merge, do_merge, do_enq, wr_ack;
  logic               rd_eligible, retire, rd_done;

  assign youngest   = tail_q - 1'b1;
  assign fifo_empty = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign head_busy  = (state_q == ST_WRITE);

  // A read must not overtake any queued or in-flight write to the same word.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [PTR_W-1:0] idx;
    assign idx     = head_q + PTR_W'(gi);
    assign hit[gi] = (CNT_W'(gi) < count_q) && (fifo_addr_q[idx] == req_addr_q);
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign merge_val[gi*8 +: 8] = req_bsel_q[gi] ? req_val_q[gi*8 +: 8] : fifo_val_q[youngest][gi*8 +: 8];
  end

  // The youngest entry is only frozen when it is also the head currently on the bus.
  assign can_merge   = MERGE && !fifo_empty && (fifo_addr_q[youngest] == req_addr_q) &&
                       !(head_busy && count_q == CNT_W'(1));
  assign do_merge    = req_valid_q && req_wr_q && can_merge;
  assign do_enq      = req_valid_q && req_wr_q && !can_merge && !full;
  assign wr_ack      = do_merge || do_enq;
  assign rd_eligible = req_valid_q && !req_wr_q &&
                       ((READ_BYPASS && !(|hit)) || (fifo_empty && state_q == ST_IDLE));
  assign retire      = (state_q == ST_WRITE) && m_ack;
  assign rd_done     = (state_q == ST_READ) && m_ack;

  always_comb begin
    state_d         = state_q;
    head_d          = head_q + PTR_W'(retire);
    tail_d          = tail_q + PTR_W'(do_enq);
    count_d         = count_q + CNT_W'(do_enq) - CNT_W'(retire);
    req_valid_d     = req_valid_q;
    req_wr_d        = req_wr_q;
    req_addr_d      = req_addr_q;
    req_val_d       = req_val_q;
    req_bsel_d      = req_bsel_q;
    rd_ack_d        = 1'b0;
    rd_err_d        = 1'b0;
    rd_data_d       = '0;
    err_sticky_d    = err_sticky_q;
    err_addr_d      = err_addr_q;

    if (wr_ack || rd_done) req_valid_d = 1'b0;
    if (c_access) begin
      req_valid_d = 1'b1;
      req_wr_d    = c_wr_en;
      req_addr_d  = c_addr;
      req_val_d   = c_wr_val;
      req_bsel_d  = c_bytesel;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rd_eligible)      state_d = ST_READ;
        else if (!fifo_empty) state_d = ST_WRITE;
      end
      ST_WRITE: if (m_ack) state_d = ST_IDLE;
      ST_READ: begin
        if (m_ack) begin
          state_d   = ST_IDLE;
          rd_ack_d  = 1'b1;
          rd_data_d = m_data;
          rd_err_d  = m_error;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new failure in the clearing cycle survives and starts a fresh capture.
    if (retire && m_error) begin
      err_sticky_d = 1'b1;
      if (!err_sticky_q || err_clr) err_addr_d = fifo_addr_q[head_q];
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
      err_addr_d   = '0;
    end

    flush_pending_d = c_flush || (flush_pending_q && !wb_empty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      req_valid_q     <= 1'b0;
      req_wr_q        <= 1'b0;
      req_addr_q      <= '0;
      req_val_q       <= '0;
      req_bsel_q      <= '0;
      rd_ack_q        <= 1'b0;
      rd_err_q        <= 1'b0;
      rd_data_q       <= '0;
      flush_pending_q <= 1'b0;
      err_sticky_q    <= 1'b0;
      err_addr_q      <= '0;
    end else begin
      state_q         <= state_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      req_valid_q     <= req_valid_d;
      req_wr_q        <= req_wr_d;
      req_addr_q      <= req_addr_d;
      req_val_q       <= req_val_d;
      req_bsel_q      <= req_bsel_d;
      rd_ack_q        <= rd_ack_d;
      rd_err_q        <= rd_err_d;
      rd_data_q       <= rd_data_d;
      flush_pending_q <= flush_pending_d;
      err_sticky_q    <= err_sticky_d;
      err_addr_q      <= err_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      fifo_addr_q[tail_q] <= req_addr_q;
      fifo_val_q[tail_q]  <= req_val_q;
      fifo_bsel_q[tail_q] <= req_bsel_q;
    end
    if (do_merge) begin
      fifo_val_q[youngest]  <= merge_val;
      fifo_bsel_q[youngest] <= fifo_bsel_q[youngest] | req_bsel_q;
    end
  end

  // Bus fields come straight from the head entry, which cannot change while it is in flight.
  assign m_access       = (state_q != ST_IDLE);
  assign m_wr_en        = (state_q == ST_WRITE);
  assign m_addr         = (state_q == ST_WRITE) ? fifo_addr_q[head_q] :
                          (state_q == ST_READ)  ? req_addr_q : '0;
  assign m_wr_val       = (state_q == ST_WRITE) ? fifo_val_q[head_q] : '0;
  assign m_bytesel      = (state_q == ST_WRITE) ? fifo_bsel_q[head_q] :
                          (state_q == ST_READ)  ? req_bsel_q : '0;
  assign c_ack          = wr_ack || rd_ack_q;
  assign c_data         = rd_data_q;
  assign c_error        = rd_err_q;
  assign wb_empty       = fifo_empty && (state_q == ST_IDLE);
  assign wb_full        = full;
  assign flush_complete = flush_pending_q && wb_empty;
  assign err_sticky     = err_sticky_q;
  assign err_addr       = err_addr_q;

endmodule
